// File: rtl/double_port_pipelined_sram_if.sv
// Port bundle for double_port_pipelined_sram: write port A, read port B and status flags.
interface double_port_pipelined_sram_if #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned AW    = 12
);
   logic             REB;
   logic             WEB;
   logic [AW-1:0]    AA;
   logic [AW-1:0]    AB;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] M;
   logic [WIDTH-1:0] Q;
   logic             QV;
   logic             BUSY;
   logic             COLL;

   modport master (output REB, WEB, AA, AB, D, M, input Q, QV, BUSY, COLL);
   modport slave  (input REB, WEB, AA, AB, D, M, output Q, QV, BUSY, COLL);
endinterface

// File: rtl/double_port_pipelined_sram.sv
// Double-port SRAM model: masked write port, pipelined read port, post-reset zero-clear.
// Define DP_SRAM_WRITE_THROUGH_EN to return the merged new row on a read/write collision.
module double_port_pipelined_sram #(
   parameter int unsigned WIDTH        = 128,
   parameter int unsigned NUM_ROWS     = 4096,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                          CLK,
   input  logic                          RST,
   double_port_pipelined_sram_if.slave   bus
);
   localparam int unsigned AddressWidth = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam logic [AddressWidth:0]   RowsExt = (AddressWidth + 1)'(NUM_ROWS);
   localparam logic [AddressWidth-1:0] LastRow = AddressWidth'(NUM_ROWS - 1);

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("double_port_pipelined_sram: READ_LATENCY %0d outside 1..4", READ_LATENCY);
   end

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t                  state_q, state_d;
   logic [AddressWidth-1:0] cnt_q, cnt_d;
   logic                    clr_we_c, busy_d;
   logic [WIDTH-1:0]        mem [NUM_ROWS];
   logic                    ready_c, wr_en_c, rd_en_c, coll_c, out_vld_c;
   logic [WIDTH-1:0]        wr_merge_c, rd_data_c, out_data_c;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Clear sequencer: one row per edge; BUSY drops on the edge that writes the last row.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clr_we_c = 1'b0;
      busy_d   = 1'b0;
      case (state_q)
         S_CLEAR: begin
            clr_we_c = !RST;
            busy_d   = 1'b1;
            if (cnt_q == LastRow) begin
               state_d = S_READY;
               busy_d  = 1'b0;
            end else begin
               cnt_d = AddressWidth'(cnt_q + 1'b1);
            end
         end
         default: busy_d = 1'b0;
      endcase
   end

   assign ready_c    = (state_q == S_READY);
   assign wr_en_c    = ready_c && !bus.WEB && ({1'b0, bus.AA} < RowsExt);
   assign rd_en_c    = ready_c && !bus.REB;
   assign coll_c     = wr_en_c && rd_en_c && (bus.AA == bus.AB);
   assign wr_merge_c = (bus.D & ~bus.M) | (mem[bus.AA] & bus.M);

   // Array has no reset on purpose; contents are zeroed by the sequencer instead.
   always_ff @(posedge CLK) begin
      if (clr_we_c) begin
         mem[cnt_q] <= '0;
      end else if (wr_en_c) begin
         mem[bus.AA] <= wr_merge_c;
      end
   end

   always_comb begin
      rd_data_c = '0;
      if ({1'b0, bus.AB} < RowsExt) begin
         rd_data_c = mem[bus.AB];
      end
`ifdef DP_SRAM_WRITE_THROUGH_EN
      if (coll_c) begin
         rd_data_c = wr_merge_c;
      end
`endif
   end

   // Latency 1 feeds Q directly; larger latencies add READ_LATENCY-1 register stages.
   if (READ_LATENCY <= 1) begin : g_direct
      assign out_vld_c  = rd_en_c;
      assign out_data_c = rd_data_c;
   end else begin : g_pipe
      localparam int Stages = int'(READ_LATENCY) - 1;
      logic [WIDTH-1:0] pipe_data [Stages];
      logic             pipe_vld  [Stages];

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            for (int i = 0; i < Stages; i++) begin
               pipe_vld[i]  <= 1'b0;
               pipe_data[i] <= '0;
            end
         end else begin
            pipe_vld[0]  <= rd_en_c;
            pipe_data[0] <= rd_data_c;
            for (int i = 1; i < Stages; i++) begin
               pipe_vld[i]  <= pipe_vld[i-1];
               pipe_data[i] <= pipe_data[i-1];
            end
         end
      end

      assign out_vld_c  = pipe_vld[Stages-1];
      assign out_data_c = pipe_data[Stages-1];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bus.Q    <= '0;
         bus.QV   <= 1'b0;
         bus.COLL <= 1'b0;
         bus.BUSY <= 1'b1;
      end else begin
         bus.QV   <= out_vld_c;
         bus.COLL <= coll_c;
         bus.BUSY <= busy_d;
         if (out_vld_c) begin
            bus.Q <= out_data_c;
         end
      end
   end
endmodule

// File: tb/tb_double_port_pipelined_sram.sv
// Directed bench: four 16x8 instances (latency 1..4) share stimulus; a 12-row instance covers range checks.
module tb_double_port_pipelined_sram;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       reb = 1'b1, web = 1'b1;
   logic [3:0] aa = '0, ab = '0;
   logic [7:0] d = '0, m = '0;
   logic       reb12 = 1'b1, web12 = 1'b1;
   logic [3:0] aa12 = '0, ab12 = '0;

   logic [7:0] q_a    [1:4];
   logic       qv_a   [1:4];
   logic       busy_a [1:4];
   logic       coll_a [1:4];
   logic [7:0] q12;
   logic       qv12, busy12, coll12;

   int checks = 0;
   int errors = 0;

   logic [3:0] rd_addr [16];
   logic [7:0] rd_exp  [16];
   bit         coll_wr = 1'b0;
   logic [3:0] coll_aa = '0;
   logic [7:0] coll_d = '0, coll_m = '0;

   always #5 CLK = ~CLK;

   for (genvar g = 1; g <= 4; g++) begin : g_lat
      double_port_pipelined_sram_if #(.WIDTH(8), .AW(4)) bus ();
      assign bus.REB = reb;
      assign bus.WEB = web;
      assign bus.AA  = aa;
      assign bus.AB  = ab;
      assign bus.D   = d;
      assign bus.M   = m;
      double_port_pipelined_sram #(.WIDTH(8), .NUM_ROWS(16), .READ_LATENCY(g)) dut (
         .CLK(CLK), .RST(RST), .bus(bus)
      );
      assign q_a[g]    = bus.Q;
      assign qv_a[g]   = bus.QV;
      assign busy_a[g] = bus.BUSY;
      assign coll_a[g] = bus.COLL;
   end

   double_port_pipelined_sram_if #(.WIDTH(8), .AW(4)) bus12 ();
   assign bus12.REB = reb12;
   assign bus12.WEB = web12;
   assign bus12.AA  = aa12;
   assign bus12.AB  = ab12;
   assign bus12.D   = d;
   assign bus12.M   = m;
   double_port_pipelined_sram #(.WIDTH(8), .NUM_ROWS(12), .READ_LATENCY(2)) dut12 (
      .CLK(CLK), .RST(RST), .bus(bus12)
   );
   assign q12    = bus12.Q;
   assign qv12   = bus12.QV;
   assign busy12 = bus12.BUSY;
   assign coll12 = bus12.COLL;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Reads are issued throughout so that any leak past BUSY shows up as a QV pulse.
   task automatic busy_seq();
      reb = 1'b0;
      ab  = 4'd0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge CLK); #1;
         for (int k = 1; k <= 4; k++) begin
            chk($sformatf("busy_l%0d_e%0d", k, i), busy_a[k], (i < 16));
            chk($sformatf("busy_qv_l%0d_e%0d", k, i), qv_a[k], 0);
         end
         chk($sformatf("busy12_e%0d", i), busy12, (i < 12));
         chk($sformatf("busy12_qv_e%0d", i), qv12, 0);
      end
      reb = 1'b1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] dv, input logic [7:0] mv);
      web = 1'b0; aa = a; d = dv; m = mv;
      @(posedge CLK); #1;
      web = 1'b1;
   endtask

   // Back-to-back reads from rd_addr; latency k shows read c after edge c+k-1.
   task automatic do_reads(input int n);
      for (int c = 0; c < n + 3; c++) begin
         if (c < n) begin
            reb = 1'b0;
            ab  = rd_addr[c];
         end else begin
            reb = 1'b1;
         end
         if (c == 0 && coll_wr) begin
            web = 1'b0; aa = coll_aa; d = coll_d; m = coll_m;
         end
         @(posedge CLK); #1;
         web = 1'b1;
         for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = c - (k - 1);
            if (idx >= 0 && idx < n) begin
               chk($sformatf("qv_l%0d_c%0d", k, c), qv_a[k], 1);
               chk($sformatf("q_l%0d_c%0d", k, c), q_a[k], rd_exp[idx]);
            end else begin
               chk($sformatf("qv_idle_l%0d_c%0d", k, c), qv_a[k], 0);
            end
            chk($sformatf("coll_l%0d_c%0d", k, c), coll_a[k], (c == 0 && coll_wr));
         end
      end
      @(posedge CLK); #1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("hold_qv_l%0d", k), qv_a[k], 0);
         chk($sformatf("hold_q_l%0d", k), q_a[k], rd_exp[n-1]);
      end
   endtask

   task automatic wr12(input logic [3:0] a, input logic [7:0] dv);
      web12 = 1'b0; aa12 = a; d = dv; m = 8'h00;
      @(posedge CLK); #1;
      web12 = 1'b1;
   endtask

   task automatic r12(input logic [3:0] a, input logic [7:0] want);
      reb12 = 1'b0; ab12 = a;
      @(posedge CLK); #1;
      reb12 = 1'b1;
      chk($sformatf("r12_qv_early_a%0d", a), qv12, 0);
      @(posedge CLK); #1;
      chk($sformatf("r12_qv_a%0d", a), qv12, 1);
      chk($sformatf("r12_q_a%0d", a), q12, want);
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("rst_q_l%0d", k), q_a[k], 8'h00);
         chk($sformatf("rst_qv_l%0d", k), qv_a[k], 0);
         chk($sformatf("rst_busy_l%0d", k), busy_a[k], 1);
         chk($sformatf("rst_coll_l%0d", k), coll_a[k], 0);
      end
      chk("rst_busy12", busy12, 1);
      chk("rst_coll12", coll12, 0);
      RST = 1'b0;
      busy_seq();

      for (int r = 0; r < 16; r++) begin
         rd_addr[r] = 4'(r);
         rd_exp[r]  = 8'h00;
      end
      do_reads(16);

      wr(4'd3, 8'hA5, 8'h00);
      rd_addr[0] = 4'd3; rd_exp[0] = 8'hA5;
      do_reads(1);

      wr(4'd5, 8'hFF, 8'h00);
      wr(4'd5, 8'h00, 8'hF0);
      rd_addr[0] = 4'd5; rd_exp[0] = 8'hF0;
      do_reads(1);

      wr(4'd7, 8'h11, 8'h00);
      coll_wr = 1'b1; coll_aa = 4'd7; coll_d = 8'h22; coll_m = 8'h00;
      rd_addr[0] = 4'd7;
`ifdef DP_SRAM_WRITE_THROUGH_EN
      rd_exp[0] = 8'h22;
`else
      rd_exp[0] = 8'h11;
`endif
      do_reads(1);
      coll_wr = 1'b0;
      rd_addr[0] = 4'd7; rd_exp[0] = 8'h22;
      do_reads(1);

      wr(4'd0, 8'h10, 8'h00);
      wr(4'd1, 8'h21, 8'h00);
      wr(4'd2, 8'h32, 8'h00);
      rd_addr[0] = 4'd0; rd_exp[0] = 8'h10;
      rd_addr[1] = 4'd1; rd_exp[1] = 8'h21;
      rd_addr[2] = 4'd2; rd_exp[2] = 8'h32;
      do_reads(3);

      wr12(4'd13, 8'h5A);
      wr12(4'd11, 8'hC3);
      r12(4'd11, 8'hC3);
      r12(4'd13, 8'h00);
      r12(4'd5, 8'h00);

      RST = 1'b1;
      #1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("rst2_q_l%0d", k), q_a[k], 8'h00);
         chk($sformatf("rst2_qv_l%0d", k), qv_a[k], 0);
         chk($sformatf("rst2_busy_l%0d", k), busy_a[k], 1);
      end
      chk("rst2_q12", q12, 8'h00);
      #1;
      RST = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(posedge CLK); #1;
         chk($sformatf("partial_busy_e%0d", i), busy_a[1], 1);
      end
      RST = 1'b1;
      #1;
      chk("rst3_busy", busy_a[4], 1);
      chk("rst3_qv", qv_a[4], 0);
      RST = 1'b0;
      busy_seq();

      rd_addr[0] = 4'd3; rd_exp[0] = 8'h00;
      rd_addr[1] = 4'd7; rd_exp[1] = 8'h00;
      rd_addr[2] = 4'd0; rd_exp[2] = 8'h00;
      do_reads(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
